// File: rtl/soc_dp_ram.sv
// True dual-port byte-writable RAM with a latency-aligned per-port ack pipeline.
// Port A wins byte conflicts on simultaneous same-word writes; cross-port readers always see the old word.
module soc_dp_ram #(
  parameter logic [31:0] p_addr_base = 32'h10000000,
  parameter logic [31:0] p_addr_mask = 32'hfffff000,
  parameter int          p_data_w    = 32,
  parameter int          p_depth_pw2 = 13,
  parameter int          p_rd_lat    = 1,
  parameter int          p_wr_mode   = 0,
  parameter int          p_init_mem  = 0,
  parameter string       p_init_file = "init_file.hex"
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_a_addr,
  input  logic [p_data_w/8-1:0] i_a_be,
  input  logic                  i_a_wr_en,
  input  logic [p_data_w-1:0]   i_a_wr_data,
  input  logic                  i_a_rd_en,
  output logic [p_data_w-1:0]   o_a_rd_data,
  output logic                  o_a_ack,
  input  logic [31:0]           i_b_addr,
  input  logic [p_data_w/8-1:0] i_b_be,
  input  logic                  i_b_wr_en,
  input  logic [p_data_w-1:0]   i_b_wr_data,
  input  logic                  i_b_rd_en,
  output logic [p_data_w-1:0]   o_b_rd_data,
  output logic                  o_b_ack,
  output logic                  o_busy
);

  localparam int BEW   = p_data_w / 8;
  localparam int OFS   = $clog2(BEW);
  localparam int DEPTH = 2 ** p_depth_pw2;

  typedef logic [p_data_w-1:0]    word_t;
  typedef logic [p_depth_pw2-1:0] idx_t;

  if ((p_data_w % 8) != 0 || p_data_w < 8 || p_data_w > 128) begin : g_bad_data_w
    $error("soc_dp_ram: p_data_w must be a multiple of 8 in 8..128");
  end
  if (p_rd_lat != 1 && p_rd_lat != 2) begin : g_bad_rd_lat
    $error("soc_dp_ram: p_rd_lat must be 1 or 2");
  end
  if (OFS + p_depth_pw2 > 32) begin : g_bad_depth
    $error("soc_dp_ram: word index does not fit in a 32-bit address");
  end
  if ((p_addr_base & ~p_addr_mask) != 32'h0) begin : g_bad_base
    $error("soc_dp_ram: p_addr_base is not aligned to the window mask");
  end
  if (p_init_mem != 0) begin : g_init_note
    $info("soc_dp_ram: mem_q is preloaded from %s by the simulation harness", p_init_file);
  end

  // Request/ack: a request is any cycle with wr_en | rd_en; it is always accepted
  // (no ready), and exactly one ack pulse follows p_rd_lat edges later, in order.
  word_t          mem_q [DEPTH];

  logic [31:0]    ofs      [2];
  idx_t           idx      [2];
  logic           in_wr    [2];
  logic           in_rd    [2];
  logic [BEW-1:0] in_be    [2];
  word_t          in_wdata [2];
  logic           wr_do    [2];
  word_t          rd_word  [2];

  always_comb begin
    ofs[0]      = i_a_addr & ~p_addr_mask;
    ofs[1]      = i_b_addr & ~p_addr_mask;
    in_wr[0]    = i_a_wr_en;
    in_wr[1]    = i_b_wr_en;
    in_rd[0]    = i_a_rd_en;
    in_rd[1]    = i_b_rd_en;
    in_be[0]    = i_a_be;
    in_be[1]    = i_b_be;
    in_wdata[0] = i_a_wr_data;
    in_wdata[1] = i_b_wr_data;
    for (int p = 0; p < 2; p++) begin
      idx[p]     = ofs[p][OFS +: p_depth_pw2];
      wr_do[p]   = in_wr[p] & i_rst_n;
      rd_word[p] = mem_q[idx[p]];
      // Write-first merges only this port's own write; the other port's write stays invisible.
      if (p_wr_mode == 1 && in_wr[p]) begin
        for (int i = 0; i < BEW; i++) begin
          if (in_be[p][i]) rd_word[p][8*i +: 8] = in_wdata[p][8*i +: 8];
        end
      end
    end
  end

  logic unused_ofs_bits;
  assign unused_ofs_bits = ^{ofs[0], ofs[1]};

  // Port B is applied first so port A's bytes take precedence on a shared word.
  always_ff @(posedge i_clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr_do[p]) begin
        for (int i = 0; i < BEW; i++) begin
          if (in_be[p][i]) mem_q[idx[p]][8*i +: 8] <= in_wdata[p][8*i +: 8];
        end
      end
    end
  end

  logic  ack1_d  [2];
  logic  ack1_q  [2];
  word_t data1_d [2];
  word_t data1_q [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      ack1_d[p]  = in_wr[p] | in_rd[p];
      data1_d[p] = in_rd[p] ? rd_word[p] : data1_q[p];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!i_rst_n) begin
        ack1_q[p]  <= 1'b0;
        data1_q[p] <= '0;
      end else begin
        ack1_q[p]  <= ack1_d[p];
        data1_q[p] <= data1_d[p];
      end
    end
  end

  logic  ack_out  [2];
  word_t data_out [2];

  if (p_rd_lat == 2) begin : g_lat2
    logic  rd1_d   [2];
    logic  rd1_q   [2];
    logic  ack2_d  [2];
    logic  ack2_q  [2];
    word_t data2_d [2];
    word_t data2_q [2];

    always_comb begin
      for (int p = 0; p < 2; p++) begin
        rd1_d[p]   = in_rd[p];
        ack2_d[p]  = ack1_q[p];
        data2_d[p] = rd1_q[p] ? data1_q[p] : data2_q[p];
      end
    end

    always_ff @(posedge i_clk) begin
      for (int p = 0; p < 2; p++) begin
        if (!i_rst_n) begin
          rd1_q[p]   <= 1'b0;
          ack2_q[p]  <= 1'b0;
          data2_q[p] <= '0;
        end else begin
          rd1_q[p]   <= rd1_d[p];
          ack2_q[p]  <= ack2_d[p];
          data2_q[p] <= data2_d[p];
        end
      end
    end

    always_comb begin
      for (int p = 0; p < 2; p++) begin
        ack_out[p]  = ack2_q[p];
        data_out[p] = data2_q[p];
      end
    end
  end else begin : g_lat1
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        ack_out[p]  = ack1_q[p];
        data_out[p] = data1_q[p];
      end
    end
  end

  assign o_a_ack     = ack_out[0];
  assign o_a_rd_data = data_out[0];
  assign o_b_ack     = ack_out[1];
  assign o_b_rd_data = data_out[1];
  assign o_busy      = 1'b0;

endmodule
